// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arbState_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int IDX_W = 6;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant policy for the memory arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin on conflicts; otherwise data has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic      i_ifReq,
  input  logic      i_dReq,
  input  logic      i_last,
  input  arbState_t i_state,
  output logic      o_ifGnt,
  output logic      o_dGnt
);

`ifndef ARB_ROUND_ROBIN_EN
  logic w_unusedLast;
  assign w_unusedLast = i_last;
`endif

  // While locked only the data side may proceed; conflicts resolve by policy.
  always_comb begin
    o_ifGnt = 1'b0;
    o_dGnt  = 1'b0;
    if (i_state == ARB_LOCKED) begin
      o_dGnt = i_dReq;
    end else if (i_ifReq && i_dReq) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (i_last == OWN_D) begin
        o_ifGnt = 1'b1;
      end else begin
        o_dGnt = 1'b1;
      end
`else
      o_dGnt = 1'b1;
`endif
    end else begin
      o_ifGnt = i_ifReq;
      o_dGnt  = i_dReq;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one combinational-read memory between fetch and load/store ports,
// with registered read data and a data-side lock. Policy macro: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_LO = 2
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_if_req,
  input  logic [ADDR_W-1:0] w_if_addr,
  output logic              w_if_gnt,
  output logic              w_if_rvalid,
  output logic [DATA_W-1:0] w_if_rdata,
  input  logic              w_d_req,
  input  logic              w_d_we,
  input  logic              w_d_lock,
  input  logic [ADDR_W-1:0] w_d_addr,
  input  logic [DATA_W-1:0] w_d_wdata,
  output logic              w_d_gnt,
  output logic              w_d_rvalid,
  output logic [DATA_W-1:0] w_d_rdata,
  output logic [ADDR_W-1:0] w_mem_addr,
  output logic              w_mem_we,
  output logic [DATA_W-1:0] w_mem_wdata,
  input  logic [DATA_W-1:0] w_mem_rdata
);

  // The memory decodes the word index itself; the full byte address is forwarded.
  localparam int unusedIdxHi = IDX_LO + IDX_W - 1;

  arbState_t         r_state;
  arbState_t         w_stateNext;
  logic              r_last;
  logic              w_pickIf;
  logic              w_pickD;
  logic              w_ifGnt;
  logic              w_dGnt;
  logic              r_ifRvalid;
  logic              r_dRvalid;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_dRdata;

  mem_arb_pick u_pick (
    .i_ifReq (w_if_req),
    .i_dReq  (w_d_req),
    .i_last  (r_last),
    .i_state (r_state),
    .o_ifGnt (w_pickIf),
    .o_dGnt  (w_pickD)
  );

  // No access may be granted while reset is held.
  assign w_ifGnt = w_pickIf & ~w_rst;
  assign w_dGnt  = w_pickD & ~w_rst;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= ARB_IDLE;
      r_last  <= OWN_IF;
    end else begin
      r_state <= w_stateNext;
      if (w_dGnt) begin
        r_last <= OWN_D;
      end else if (w_ifGnt) begin
        r_last <= OWN_IF;
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_mem_addr  = '0;
    w_mem_we    = 1'b0;
    w_mem_wdata = w_d_wdata;
    case (r_state)
      ARB_IDLE: begin
        if (w_dGnt && w_d_lock) begin
          w_stateNext = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if ((w_dGnt && !w_d_lock) || (!w_d_req && !w_d_lock)) begin
          w_stateNext = ARB_IDLE;
        end
      end
      default: w_stateNext = ARB_IDLE;
    endcase
    if (w_dGnt) begin
      w_mem_addr = w_d_addr;
      w_mem_we   = w_d_we;
    end else if (w_ifGnt) begin
      w_mem_addr = w_if_addr;
    end
  end

  // Read data is captured in the grant cycle and presented one cycle later.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_ifRvalid <= 1'b0;
      r_dRvalid  <= 1'b0;
      r_ifRdata  <= '0;
      r_dRdata   <= '0;
    end else begin
      r_ifRvalid <= w_ifGnt;
      r_dRvalid  <= w_dGnt & ~w_d_we;
      if (w_ifGnt) begin
        r_ifRdata <= w_mem_rdata;
      end
      if (w_dGnt && !w_d_we) begin
        r_dRdata <= w_mem_rdata;
      end
    end
  end

  assign w_if_gnt    = w_ifGnt;
  assign w_d_gnt     = w_dGnt;
  assign w_if_rvalid = r_ifRvalid;
  assign w_d_rvalid  = r_dRvalid;
  assign w_if_rdata  = r_ifRdata;
  assign w_d_rdata   = r_dRdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port 64-word data memory between the instruction-fetch requester and the load/store requester of the CPU. It sits between the core and an `m_mem`-style memory, which has a combinational read and a write committed at the clock edge. The arbiter turns that memory into two independent request/grant ports with registered read data. It also provides a lock so the load/store side can perform back-to-back accesses without being interleaved with fetches.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width on both requester ports.
- `DATA_W`, default 32: word width.
- `IDX_LO`, default 2: low bit of the word index; memory index is `addr[IDX_LO+5:IDX_LO]`.

Ports (all synchronous to `w_clk` except reset):
- `w_clk`  in  1  clock; all state updates on the rising edge.
- `w_rst`  in  1  asynchronous, active-high reset.
- `w_if_req`  in  1  fetch request; held with `w_if_addr` stable until granted.
- `w_if_addr`  in  ADDR_W  fetch byte address.
- `w_if_gnt`  out  1  fetch accepted this cycle.
- `w_if_rvalid`  out  1  `w_if_rdata` valid; one cycle after `w_if_gnt`.
- `w_if_rdata`  out  DATA_W  registered fetch data.
- `w_d_req`  in  1  load/store request; held with its fields stable until granted.
- `w_d_we`  in  1  1 = store, 0 = load.
- `w_d_lock`  in  1  keep ownership after this grant.
- `w_d_addr`  in  ADDR_W  data byte address.
- `w_d_wdata`  in  DATA_W  store data.
- `w_d_gnt`  out  1  data access accepted this cycle.
- `w_d_rvalid`  out  1  `w_d_rdata` valid; one cycle after a load grant only.
- `w_d_rdata`  out  DATA_W  registered load data.
- `w_mem_addr`  out  ADDR_W  memory address (granted requester's address; 0 when idle).
- `w_mem_we`  out  1  memory write enable; asserted only with `w_d_gnt & w_d_we`.
- `w_mem_wdata`  out  DATA_W  memory write data.
- `w_mem_rdata`  in  DATA_W  combinational memory read data.

## Operation
- At most one grant per cycle. `w_if_gnt` and `w_d_gnt` are never both 1.
- Grants are combinational from the current requests and state. The access is performed in the grant cycle.
- FSM states:
  - `IDLE`: grants follow the arbitration policy. A data grant with `w_d_lock=1` moves the FSM to `LOCKED`.
  - `LOCKED`: only the data port can be granted. The FSM returns to `IDLE` on a data grant with `w_d_lock=0`, or on any cycle with `w_d_req=0 & w_d_lock=0`.
- Fetch requests are never granted in `LOCKED`.
- Last-owner register `r_last`: 0 = fetch, 1 = data. It updates on every grant.
- Read path:
  - On a fetch grant, `w_mem_rdata` is captured into `w_if_rdata` and `w_if_rvalid` pulses high for one cycle.
  - On a load grant, the same applies to `w_d_rdata` and `w_d_rvalid`.
  - A store grant produces no `w_d_rvalid`.
- `rdata` registers hold their value until the next capture for the same port.
- A store and a later load to the same address in back-to-back grants return the stored value, because the write commits at the edge that ends the store grant cycle.
- Requests are not queued. A requester keeps `req` asserted until it sees `gnt`.

## Timing
- Reset values:
  - FSM = `IDLE`, `r_last` = 0.
  - `w_if_rvalid` = `w_d_rvalid` = 0.
  - `w_if_rdata` = `w_d_rdata` = 0.
  - Both gnt outputs forced 0 while `w_rst` is high.
  - `w_mem_we` forced 0 while `w_rst` is high.
- Grant latency: 0 cycles when the port wins arbitration.
- Read data latency: exactly 1 cycle after the grant.
- Uncontested throughput: one access per cycle per port.
- Reset asserted mid-sequence: `LOCKED` is abandoned, no rvalid is produced for a grant in the reset cycle, and no memory write occurs.
- A request deasserted without a grant is legal. Nothing is recorded.

## Configuration
- Macro `ARB_ROUND_ROBIN_EN`.
- Defined: round-robin policy. On a simultaneous request in `IDLE`, the port that is not `r_last` wins. With `r_last`=0 after reset, data wins the first conflict.
- Undefined: fixed priority. Data always wins a simultaneous request in `IDLE`, and `r_last` is unused. Fetch can be starved; this is acceptable for the single-issue core.

## Structure
- The shared package `mem_arb_pkg` holds:
  - the FSM state enum (`ARB_IDLE`, `ARB_LOCKED`);
  - owner encoding constants (`OWN_IF`, `OWN_D`);
  - the index-width constant 6.
- One sub-module, `mem_arb_pick`: the combinational policy. Inputs are both reqs, `r_last` and the state; outputs are the two grants. Only this sub-module changes under `ARB_ROUND_ROBIN_EN`.

## Test plan
- Reset, then fetch-only request to address 0x8 with mem[2]=0x00500093 -> `w_if_gnt`=1 the same cycle; next cycle `w_if_rvalid`=1 and `w_if_rdata`=0x00500093.
- Store 0xDEADBEEF to address 0x10, then load from 0x10 the next cycle -> `w_mem_we` high for one cycle only; the load gives `w_d_rvalid`=1 and `w_d_rdata`=0xDEADBEEF; no `w_d_rvalid` after the store.
- Both ports request continuously for 6 cycles:
  - with `ARB_ROUND_ROBIN_EN`, grants alternate D, IF, D, IF, D, IF;
  - without it, all 6 grants go to D and `w_if_gnt` stays 0.
- Data grant with `w_d_lock`=1, then 3 locked loads while fetch requests -> `w_if_gnt`=0 throughout; fetch is granted in the cycle after the data grant with `w_d_lock`=0.
- `w_rst` pulsed while in `LOCKED` with both reqs high -> both gnts are 0 and `w_mem_we`=0 during reset; after release the FSM is `IDLE` and the next conflict goes to D.
